// File: rtl/clk_div_prog_if.sv
// Divisor load handshake and divided-clock outputs of the programmable divider.
interface clk_div_prog_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic [CNT_W-1:0] div_cur;
    logic             div_out;
    logic             tick;

    modport master (
        output en, div_in, div_load,
        input  div_busy, div_err, div_cur, div_out, tick
    );

    modport slave (
        input  en, div_in, div_load,
        output div_busy, div_err, div_cur, div_out, tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: divided level, per-period tick, and a
// divisor reload that only takes effect on a period boundary.
module clk_div_prog #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_prog_if.slave bus
);

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             err;
    logic             div_out;
    logic             tick;

    logic [CNT_W-1:0] last_c;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic [CNT_W-1:0] hi_c;
    logic             wrap_c;
    logic             load_ok_c;
    logic             load_bad_c;
    logic             apply_c;

    // Period bookkeeping and handshake decode for the current cycle.
    always_comb begin
        last_c     = div_cur - ONE;
        wrap_c     = (cnt == last_c);
        cnt_nxt_c  = wrap_c ? '0 : cnt + ONE;
        hi_c       = div_cur - (div_cur >> 1);
        load_ok_c  = bus.div_load && (bus.div_in >= MIN_N);
        load_bad_c = bus.div_load && (bus.div_in < MIN_N);
        // A frozen divider has no boundary to wait for, so it applies at once.
        apply_c    = busy && (!bus.en || wrap_c);
    end

    // Counter, divided output, tick and divisor reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_cur <= DEF_N;
            pending <= DEF_N;
            busy    <= 1'b0;
            err     <= 1'b0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            err  <= load_bad_c;
            tick <= bus.en && wrap_c;

            if (apply_c) begin
                // New period starts at phase 0, which is always in the high half.
                div_cur <= pending;
                cnt     <= '0;
                div_out <= 1'b1;
            end else if (bus.en) begin
                cnt     <= cnt_nxt_c;
                div_out <= (cnt_nxt_c < hi_c);
            end

            // A load on the apply edge becomes the next pending value.
            if (load_ok_c) begin
                pending <= bus.div_in;
                busy    <= 1'b1;
            end else if (apply_c) begin
                busy    <= 1'b0;
            end
        end
    end

    assign bus.div_busy = busy;
    assign bus.div_err  = err;
    assign bus.div_cur  = div_cur;
    assign bus.div_out  = div_out;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: phase-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clk_div_prog;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DEF_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the period, divisor, pending slot.
    int m_n    = DEF_DIV;
    int m_p    = 0;
    int m_pend = DEF_DIV;
    bit m_pv   = 1'b0;
    bit m_out  = 1'b0;
    bit m_tick = 1'b0;
    bit m_err  = 1'b0;
    bit m_end;
    bit m_apply;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = DEF_DIV; m_p = 0; m_pend = DEF_DIV; m_pv = 0;
            m_out = 0; m_tick = 0; m_err = 0;
        end else begin
            m_end   = (m_p == m_n - 1);
            m_apply = m_pv && (!bus.en || m_end);
            m_err   = bus.div_load && (int'(bus.div_in) < 2);
            m_tick  = bus.en && m_end;
            if (m_apply) begin
                m_n = m_pend; m_p = 0; m_pv = 0; m_out = 1;
            end else if (bus.en) begin
                m_p   = (m_p + 1) % m_n;
                m_out = (m_p < (m_n + 1) / 2);
            end
            if (bus.div_load && int'(bus.div_in) >= 2) begin
                m_pend = int'(bus.div_in); m_pv = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("div_out", int'(bus.div_out), int'(m_out));
        check("tick", int'(bus.tick), int'(m_tick));
        check("div_err", int'(bus.div_err), int'(m_err));
        check("div_busy", int'(bus.div_busy), int'(m_pv));
        check("div_cur", int'(bus.div_cur), m_n);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        bus.div_in   = CNT_W'(v);
        bus.div_load = 1'b1;
        cyc();
        bus.div_load = 1'b0;
    endtask

    // Run until busy drops; the edge that clears it is the apply edge.
    task automatic wait_apply(input int budget);
        int n;
        n = 0;
        while (bus.div_busy && n < budget) begin
            cyc();
            n++;
        end
        if (bus.div_busy) check("apply_timeout", 1, 0);
    endtask

    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        cyc();
        while (!bus.tick && n < budget) begin
            cyc();
            n++;
        end
        if (!bus.tick) check("tick_timeout", 1, 0);
    endtask

    initial begin
        logic [3:0] t1_out;
        logic [3:0] t1_tick;
        logic [4:0] t2_out;
        logic [4:0] t2_tick;
        logic       held;
        int         highs;
        int         ticks;

        bus.en = 1'b0; bus.div_in = '0; bus.div_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_div_out", int'(bus.div_out), 0);
        check("rst_tick", int'(bus.tick), 0);
        check("rst_busy", int'(bus.div_busy), 0);
        check("rst_div_cur", int'(bus.div_cur), DEF_DIV);

        // T1: N=2 after reset release.
        rst = 1'b0; bus.en = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            cyc();
            t1_out[k]  = bus.div_out;
            t1_tick[k] = bus.tick;
        end
        check("t1_div_out", int'(t1_out), 4'b0101);
        check("t1_tick", int'(t1_tick), 4'b0101);

        // T2: load 5 at idle.
        load(5);
        check("t2_busy", int'(bus.div_busy), 1);
        check("t2_cur_before", int'(bus.div_cur), 2);
        wait_apply(10);
        for (int k = 4; k >= 0; k--) begin
            t2_out[k]  = bus.div_out;
            t2_tick[k] = bus.tick;
            if (k > 0) cyc();
        end
        check("t2_div_out", int'(t2_out), 5'b11100);
        check("t2_tick", int'(t2_tick), 5'b10000);
        check("t2_div_cur", int'(bus.div_cur), 5);

        // T3: rejected loads.
        load(0);
        check("t3_err0", int'(bus.div_err), 1);
        check("t3_busy0", int'(bus.div_busy), 0);
        load(1);
        check("t3_err1", int'(bus.div_err), 1);
        check("t3_cur", int'(bus.div_cur), 5);
        cyc();
        check("t3_err_clear", int'(bus.div_err), 0);

        // T4: two loads before the wrap, only the last applies.
        wait_tick(10);
        load(7);
        load(3);
        check("t4_cur_pending", int'(bus.div_cur), 5);
        wait_apply(10);
        check("t4_div_cur", int'(bus.div_cur), 3);
        repeat (6) cyc();

        // T5: freeze mid-period, then resume.
        wait_tick(10);
        cyc();
        bus.en = 1'b0;
        cyc();
        held = bus.div_out;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t5_hold", int'(bus.div_out), int'(held));
            check("t5_tick", int'(bus.tick), 0);
        end
        bus.en = 1'b1;
        repeat (6) cyc();

        // Frozen divider applies a load on the first idle edge.
        bus.en = 1'b0;
        load(4);
        cyc();
        check("off_apply_cur", int'(bus.div_cur), 4);
        check("off_apply_out", int'(bus.div_out), 1);
        check("off_apply_tick", int'(bus.tick), 0);
        check("off_apply_busy", int'(bus.div_busy), 0);
        bus.en = 1'b1;
        repeat (5) cyc();

        // Largest divisor: 255 cycles, 128 high.
        load(255);
        wait_apply(10);
        highs = 0; ticks = 0;
        for (int k = 0; k < 255; k++) begin
            highs += int'(bus.div_out);
            ticks += int'(bus.tick);
            cyc();
        end
        check("n255_highs", highs, 128);
        check("n255_ticks", ticks, 1);
        check("n255_wrap_tick", int'(bus.tick), 1);

        // T6: async reset mid-period with a load pending.
        repeat (20) cyc();
        load(9);
        check("t6_busy_pre", int'(bus.div_busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_div_out", int'(bus.div_out), 0);
        check("t6_tick", int'(bus.tick), 0);
        check("t6_busy", int'(bus.div_busy), 0);
        check("t6_div_cur", int'(bus.div_cur), DEF_DIV);
        cyc();
        rst = 1'b0;
        repeat (12) cyc();
        check("t6_cur_after", int'(bus.div_cur), DEF_DIV);
        check("t6_busy_after", int'(bus.div_busy), 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
